// File: rtl/constants.sv
// Shared build-time constants for the issue/hazard logic.
`ifndef CONSTANTS_SV
`define CONSTANTS_SV
`define REGFILE_LOGSIZE 5
`define MAX_OUT_DEFAULT 4
`endif

// File: rtl/hazard_scoreboard_cmp.sv
// One source operand checked against the pending mask and the load-use register.
`ifndef CONSTANTS_SV
`include "constants.sv"
`endif

module hazard_cmp #(
  parameter int RW = `REGFILE_LOGSIZE
) (
  input  logic [RW-1:0]      src_i,
  input  logic               src_used_i,
  input  logic [2**RW-1:0]   pending_i,
  input  logic               ll_valid_i,
  input  logic [RW-1:0]      ll_rd_i,
  output logic               raw_hit_o,
  output logic               ld_hit_o
);

  logic live;

  always_comb begin
    live      = src_used_i && (src_i != '0);
    raw_hit_o = live && pending_i[src_i];
    ld_hit_o  = live && ll_valid_i && (src_i == ll_rd_i);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage scoreboard: load-use, RAW/WAW on long-latency writes and outstanding-op limit.
`ifndef CONSTANTS_SV
`include "constants.sv"
`endif

module hazard_scoreboard #(
  parameter int MAX_OUT = `MAX_OUT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              issue_valid,
  input  logic [`REGFILE_LOGSIZE-1:0]       issue_rs1,
  input  logic [`REGFILE_LOGSIZE-1:0]       issue_rs2,
  input  logic                              issue_rs1_used,
  input  logic                              issue_rs2_used,
  input  logic [`REGFILE_LOGSIZE-1:0]       issue_rd,
  input  logic                              issue_wr,
  input  logic                              issue_load,
  input  logic                              issue_long,
  input  logic                              wb_valid,
  input  logic [`REGFILE_LOGSIZE-1:0]       wb_rd,
  output logic                              stall,
  output logic [2**`REGFILE_LOGSIZE-1:0]    pending,
  output logic [3:0]                        outstanding
);

  localparam int RW   = `REGFILE_LOGSIZE;
  localparam int NREG = 2**RW;

  logic [NREG-1:0] pending_q, pending_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ll_valid_q, ll_valid_d;
  logic [RW-1:0]   ll_rd_q, ll_rd_d;

  logic raw1, ld1, raw2, ld2;
  logic waw_haz, full_haz, ld_haz, raw_haz;
  logic accept, set_en, clr_en, rd_nz;

  hazard_cmp #(.RW(RW)) u_cmp_rs1 (
    .src_i      (issue_rs1),
    .src_used_i (issue_rs1_used),
    .pending_i  (pending_q),
    .ll_valid_i (ll_valid_q),
    .ll_rd_i    (ll_rd_q),
    .raw_hit_o  (raw1),
    .ld_hit_o   (ld1)
  );

  hazard_cmp #(.RW(RW)) u_cmp_rs2 (
    .src_i      (issue_rs2),
    .src_used_i (issue_rs2_used),
    .pending_i  (pending_q),
    .ll_valid_i (ll_valid_q),
    .ll_rd_i    (ll_rd_q),
    .raw_hit_o  (raw2),
    .ld_hit_o   (ld2)
  );

  always_comb begin
    rd_nz    = (issue_rd != '0);
    ld_haz   = ld1 | ld2;
    raw_haz  = raw1 | raw2;
    waw_haz  = issue_wr && rd_nz && pending_q[issue_rd];
    full_haz = issue_long && (cnt_q == 4'(MAX_OUT));
    stall    = issue_valid && !flush && (ld_haz || raw_haz || waw_haz || full_haz);

    accept = issue_valid && !stall && !flush;
    set_en = accept && issue_long && issue_wr && rd_nz;
    clr_en = wb_valid && (wb_rd != '0) && pending_q[wb_rd];

    // Clear first so that a forced same-register set/clear leaves the bit set.
    pending_d = pending_q;
    if (clr_en) pending_d[wb_rd] = 1'b0;
    if (set_en) pending_d[issue_rd] = 1'b1;

    cnt_d = cnt_q;
    case ({set_en, clr_en})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase

    ll_valid_d = accept && issue_load && issue_wr && rd_nz;
    ll_rd_d    = ll_valid_d ? issue_rd : ll_rd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      cnt_q      <= '0;
      ll_valid_q <= 1'b0;
      ll_rd_q    <= '0;
    end else begin
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      ll_valid_q <= ll_valid_d;
      ll_rd_q    <= ll_rd_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random checks of hazard_scoreboard against a register-array model.
module tb_hazard_scoreboard;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_rs1_used, issue_rs2_used, issue_wr, issue_load, issue_long, wb_valid;
  logic        stall;
  logic [31:0] pending;
  logic [3:0]  outstanding;

  hazard_scoreboard #(.MAX_OUT(MAX_OUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd       (issue_rd),
    .issue_wr       (issue_wr),
    .issue_load     (issue_load),
    .issue_long     (issue_long),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .stall          (stall),
    .pending        (pending),
    .outstanding    (outstanding)
  );

  always #5 clk = ~clk;

  bit   m_pend [32];
  int   m_cnt;
  bit   m_llv;
  int   m_llrd;
  int   vectors = 0;
  int   miscompares = 0;
  logic last_stall;

  function automatic bit src_haz(input bit used, input int r);
    return used && (r != 0) && (m_pend[r] || (m_llv && (m_llrd == r)));
  endfunction

  task automatic apply(input bit rs, input bit fl, input bit v,
                       input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit lg,
                       input bit wbv, input int wbr);
    bit          exp_stall, acc;
    logic [31:0] exp_pend;
    rst = rs; flush = fl; issue_valid = v;
    issue_rs1 = 5'(r1); issue_rs1_used = u1;
    issue_rs2 = 5'(r2); issue_rs2_used = u2;
    issue_rd = 5'(rd); issue_wr = wr; issue_load = ld; issue_long = lg;
    wb_valid = wbv; wb_rd = 5'(wbr);
    #1;
    exp_stall = v && !fl && (src_haz(u1, r1) || src_haz(u2, r2) ||
                (wr && rd != 0 && m_pend[rd]) || (lg && m_cnt == MAX_OUT));
    vectors++;
    assert (stall === exp_stall) else begin
      miscompares++;
      $error("FAIL stall: observed %0b expected %0b", stall, exp_stall);
    end
    last_stall = stall;
    @(posedge clk);
    acc = v && !fl && !exp_stall;
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_llv = 1'b0;
      m_llrd = 0;
    end else begin
      if (wbv && wbr != 0) m_pend[wbr] = 1'b0;
      if (acc && lg && wr && rd != 0) m_pend[rd] = 1'b1;
      m_llv = acc && ld && wr && rd != 0;
      if (m_llv) m_llrd = rd;
    end
    m_cnt = 0;
    exp_pend = '0;
    foreach (m_pend[i]) if (m_pend[i]) begin
      m_cnt++;
      exp_pend[i] = 1'b1;
    end
    #1;
    assert (pending === exp_pend) else begin
      miscompares++;
      $error("FAIL pending: observed %h expected %h", pending, exp_pend);
    end
    assert (outstanding === 4'(m_cnt)) else begin
      miscompares++;
      $error("FAIL outstanding: observed %0d expected %0d", outstanding, m_cnt);
    end
    assert (outstanding <= 4'(MAX_OUT)) else begin
      miscompares++;
      $error("FAIL outstanding_limit: observed %0d expected <= %0d", outstanding, MAX_OUT);
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic long_op(input int rd, input bit wbv, input int wbr);
    apply(0, 0, 1, 0, 0, 0, 0, rd, 1, 0, 1, wbv, wbr);
  endtask

  task automatic wb_only(input int r);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
  endtask

  initial begin
    logic [1:0] seq;
    int nstall;
    bit rs, fl, v, u1, u2, wr, ld, lg, wbv;
    int r1, r2, rd, wbr;

    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_cnt = 0; m_llv = 1'b0; m_llrd = 0;

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // load x5 then a use of x5: exactly one bubble
    apply(0, 0, 1, 1, 1, 2, 1, 5, 1, 1, 0, 0, 0);
    apply(0, 0, 1, 5, 1, 2, 1, 8, 1, 0, 0, 0, 0);
    seq[1] = last_stall;
    apply(0, 0, 1, 5, 1, 2, 1, 8, 1, 0, 0, 0, 0);
    seq[0] = last_stall;
    vectors++;
    assert (seq === 2'b10) else begin
      miscompares++;
      $error("FAIL load_use_seq: observed %b expected 10", seq);
    end

    // long div x7, dependent add waits until the cycle after wb
    long_op(7, 0, 0);
    nstall = 0;
    for (int c = 1; c <= 10; c++) begin
      apply(0, 0, 1, 1, 0, 7, 1, 8, 1, 0, 0, (c == 10), 7);
      nstall += int'(last_stall);
    end
    apply(0, 0, 1, 1, 0, 7, 1, 8, 1, 0, 0, 0, 0);
    vectors++;
    assert (nstall == 10 && last_stall === 1'b0) else begin
      miscompares++;
      $error("FAIL raw_wait: observed %0d stalls final %0b expected 10 final 0", nstall, last_stall);
    end

    // fill to MAX_OUT, fifth long op waits for any wb
    for (int r = 1; r <= 4; r++) long_op(r, 0, 0);
    for (int k = 0; k < 3; k++) long_op(9, 0, 0);
    long_op(9, 1, 1);
    long_op(9, 0, 0);
    vectors++;
    assert (outstanding === 4'd4) else begin
      miscompares++;
      $error("FAIL full_refill: observed %0d expected 4", outstanding);
    end
    wb_only(2);
    long_op(10, 1, 3);
    vectors++;
    assert (outstanding === 4'd3) else begin
      miscompares++;
      $error("FAIL set_clr_same_cycle: observed %0d expected 3", outstanding);
    end
    wb_only(4); wb_only(9); wb_only(10);

    // r0 as destination and source
    long_op(0, 0, 0);
    apply(0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    apply(0, 0, 1, 0, 1, 0, 1, 11, 1, 0, 0, 0, 0);
    vectors++;
    assert (pending === 32'h0 && last_stall === 1'b0) else begin
      miscompares++;
      $error("FAIL r0_ignored: observed pending %h stall %0b expected 0 0", pending, last_stall);
    end

    // WAW on x3, then flush during a long issue and a pending load-use
    long_op(3, 0, 0);
    apply(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    vectors++;
    assert (last_stall === 1'b1) else begin
      miscompares++;
      $error("FAIL waw: observed %0b expected 1", last_stall);
    end
    wb_only(3);
    apply(0, 0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    apply(0, 1, 1, 6, 1, 0, 0, 12, 1, 0, 1, 0, 0);
    apply(0, 0, 1, 6, 1, 0, 0, 13, 1, 0, 0, 0, 0);
    vectors++;
    assert (pending[12] === 1'b0 && last_stall === 1'b0) else begin
      miscompares++;
      $error("FAIL flush: observed pend12 %0b stall %0b expected 0 0", pending[12], last_stall);
    end

    // reset with x4..x7 pending, stale wb afterwards
    for (int r = 4; r <= 7; r++) long_op(r, 0, 0);
    vectors++;
    assert (pending === 32'h0000_00F0) else begin
      miscompares++;
      $error("FAIL pre_reset: observed %h expected 000000f0", pending);
    end
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    wb_only(4);
    vectors++;
    assert (outstanding === 4'd0 && pending === 32'h0) else begin
      miscompares++;
      $error("FAIL stale_wb: observed %0d/%h expected 0/0", outstanding, pending);
    end

    // random traffic on a small register window to force frequent hazards
    for (int n = 0; n < 3000; n++) begin
      rs  = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 3) != 0);
      r1  = $urandom_range(0, 7);  u1 = $urandom_range(0, 1);
      r2  = $urandom_range(0, 7);  u2 = $urandom_range(0, 1);
      rd  = $urandom_range(0, 7);  wr = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 4) == 0);
      lg  = !ld && ($urandom_range(0, 2) == 0);
      wbv = ($urandom_range(0, 2) == 0);
      wbr = $urandom_range(0, 7);
      apply(rs, fl, v, r1, u1, r2, u2, rd, wr, ld, lg, wbv, wbr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
